sram22_sp_param: RTL and testbench

- Parametrised single-port synchronous SRAM behavioural model for SRAM22 macros.
- Generalises the fixed-geometry models:
  - configurable data width, depth and write-mask granularity (segments wider than 1 bit)
  - selectable read latency of 1 or 2 cycles, with a read-valid strobe
  - hardware clear-on-reset sweep, with a busy flag
- Used in RTL simulation and as the drop-in model wherever a generated macro sits in the SoC.

---
 rtl/sram22_sp_param.sv | 168 ++++++++++++++++
 tb/tb_sram22_sp_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_sp_param.sv
// Parametrised single-port synchronous SRAM model for SRAM22 macros with clear-on-reset sweep.
// Optional per-segment even parity with error injection is enabled by defining SRAM22_PARITY_EN.
module sram22_sp_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int WMASK_WIDTH    = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
`ifdef SRAM22_PARITY_EN
  input  logic                   perr_inj,
  output logic                   perr,
`endif
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   rvalid,
  output logic                   busy
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int SEG       = DATA_WIDTH / WMASK_WIDTH;

  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $fatal(1, "sram22_sp_param: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
    $fatal(1, "sram22_sp_param: DATA_WIDTH must be divisible by WMASK_WIDTH");
  end

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    fin_valid;
  logic [DATA_WIDTH-1:0]   fin_data;

  assign rd_acc = (state == ST_IDLE) && ce && !we;
  assign wr_acc = (state == ST_IDLE) && ce && we;

  // Clear-sweep FSM; busy is registered and drops on the edge that clears the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
      busy  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          busy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array storage; never reset so CLEAR_ON_RESET=0 preserves contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < WMASK_WIDTH; i++) begin
          if (wmask[i]) mem[addr][i*SEG +: SEG] <= din[i*SEG +: SEG];
        end
      end
    end
  end

`ifdef SRAM22_PARITY_EN
  logic [WMASK_WIDTH-1:0] par [RAM_DEPTH];
  logic                   fin_perr;

  function automatic logic seg_parity_fail(input logic [DATA_WIDTH-1:0] d,
                                           input logic [WMASK_WIDTH-1:0] p);
    logic f;
    f = 1'b0;
    for (int i = 0; i < WMASK_WIDTH; i++) f = f | ((^d[i*SEG +: SEG]) ^ p[i]);
    return f;
  endfunction

  // Parity bits: even parity per segment, inverted on injection, zero during the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        par[cnt] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < WMASK_WIDTH; i++) begin
          if (wmask[i]) par[addr][i] <= (^din[i*SEG +: SEG]) ^ perr_inj;
        end
      end
    end
  end
`endif

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
`ifdef SRAM22_PARITY_EN
    logic                  s1_perr;
`endif
    // Extra read stage; flushed by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
`ifdef SRAM22_PARITY_EN
        s1_perr  <= 1'b0;
`endif
      end else begin
        s1_valid <= rd_acc;
        if (rd_acc) begin
          s1_data <= mem[addr];
`ifdef SRAM22_PARITY_EN
          s1_perr <= seg_parity_fail(mem[addr], par[addr]);
`endif
        end
      end
    end
    assign fin_valid = s1_valid;
    assign fin_data  = s1_data;
`ifdef SRAM22_PARITY_EN
    assign fin_perr  = s1_perr;
`endif
  end else begin : g_lat1
    assign fin_valid = rd_acc;
    assign fin_data  = mem[addr];
`ifdef SRAM22_PARITY_EN
    assign fin_perr  = seg_parity_fail(mem[addr], par[addr]);
`endif
  end

  // Output register: dout holds its last read value until the next completing read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      rvalid <= 1'b0;
`ifdef SRAM22_PARITY_EN
      perr   <= 1'b0;
`endif
    end else begin
      rvalid <= fin_valid;
      if (fin_valid) dout <= fin_data;
`ifdef SRAM22_PARITY_EN
      perr   <= fin_valid & fin_perr;
`endif
    end
  end

endmodule

// File: tb/tb_sram22_sp_param.sv
// Directed bench for sram22_sp_param: three instances cover latency 1, latency 2 and no-clear builds.
module tb_sram22_sp_param;

  logic        clk;
  logic        rst   [3];
  logic        ce    [3];
  logic        we    [3];
  logic [3:0]  wmask [3];
  logic [8:0]  addr  [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        rvalid[3];
  logic        busy  [3];
`ifdef SRAM22_PARITY_EN
  logic        perr_inj[3];
  logic        perr    [3];
`endif

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram22_sp_param #(.READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .ce(ce[0]), .we(we[0]), .wmask(wmask[0]),
    .addr(addr[0]), .din(din[0]),
`ifdef SRAM22_PARITY_EN
    .perr_inj(perr_inj[0]), .perr(perr[0]),
`endif
    .dout(dout[0]), .rvalid(rvalid[0]), .busy(busy[0]));

  sram22_sp_param #(.READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_lat2 (
    .clk(clk), .rst(rst[1]), .ce(ce[1]), .we(we[1]), .wmask(wmask[1]),
    .addr(addr[1]), .din(din[1]),
`ifdef SRAM22_PARITY_EN
    .perr_inj(perr_inj[1]), .perr(perr[1]),
`endif
    .dout(dout[1]), .rvalid(rvalid[1]), .busy(busy[1]));

  sram22_sp_param #(.READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_noclr (
    .clk(clk), .rst(rst[2]), .ce(ce[2]), .we(we[2]), .wmask(wmask[2]),
    .addr(addr[2]), .din(din[2]),
`ifdef SRAM22_PARITY_EN
    .perr_inj(perr_inj[2]), .perr(perr[2]),
`endif
    .dout(dout[2]), .rvalid(rvalid[2]), .busy(busy[2]));

  task automatic wr(input int d, input logic [8:0] a, input logic [31:0] v, input logic [3:0] m);
    @(negedge clk);
    ce[d] = 1'b1; we[d] = 1'b1; addr[d] = a; din[d] = v; wmask[d] = m;
    @(negedge clk);
    ce[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [8:0] a);
    @(negedge clk);
    ce[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
    @(negedge clk);
    ce[d] = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    repeat (2) @(negedge clk);
    total++;
    if (busy[0] !== 1'b1 || dout[0] !== 32'h0 || rvalid[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_state busy=%b dout=%h rvalid=%b expected busy=1 dout=0 rvalid=0",
               busy[0], dout[0], rvalid[0]);
    end
    total++;
    if (busy[1] !== 1'b1 || busy[2] !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_cfg lat2_busy=%b noclr_busy=%b expected 1 and 0", busy[1], busy[2]);
    end
`ifdef SRAM22_PARITY_EN
    total++;
    if (perr[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_perr got=%b expected=0", perr[0]);
    end
`endif
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    n = 0;
    while (busy[0] === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== 512 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL clear_busy_len got=%0d cycles expected=512", n);
    end
  endtask

  task automatic test_clear_read;
    rd(0, 9'h1FF);
    total++;
    if (rvalid[0] !== 1'b1 || dout[0] !== 32'h0) begin
      bad++;
      $display("FAIL clear_read rvalid=%b dout=%h expected rvalid=1 dout=00000000", rvalid[0], dout[0]);
    end
    @(negedge clk);
    total++;
    if (rvalid[0] !== 1'b0) begin
      bad++;
      $display("FAIL rvalid_pulse got=%b expected=0", rvalid[0]);
    end
  endtask

  task automatic test_wmask;
    wr(0, 9'd5, 32'hDEADBEEF, 4'hF);
    wr(0, 9'd5, 32'h11223344, 4'b0101);
    rd(0, 9'd5);
    total++;
    if (rvalid[0] !== 1'b1 || dout[0] !== 32'hDE22BE44) begin
      bad++;
      $display("FAIL wmask_merge rvalid=%b dout=%h expected rvalid=1 dout=de22be44", rvalid[0], dout[0]);
    end
    wr(0, 9'd6, 32'hCAFEF00D, 4'hF);
    total++;
    if (rvalid[0] !== 1'b0 || dout[0] !== 32'hDE22BE44) begin
      bad++;
      $display("FAIL dout_hold_write rvalid=%b dout=%h expected rvalid=0 dout=de22be44", rvalid[0], dout[0]);
    end
    wr(0, 9'd5, 32'hFFFFFFFF, 4'h0);
    rd(0, 9'd6);
    rd(0, 9'd5);
    total++;
    if (dout[0] !== 32'hDE22BE44) begin
      bad++;
      $display("FAIL wmask_zero_noop dout=%h expected=de22be44", dout[0]);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'd9; din[0] = 32'h12345678; wmask[0] = 4'hF;
    @(negedge clk);
    we[0] = 1'b0;
    @(negedge clk);
    ce[0] = 1'b0;
    total++;
    if (rvalid[0] !== 1'b1 || dout[0] !== 32'h12345678) begin
      bad++;
      $display("FAIL write_then_read rvalid=%b dout=%h expected rvalid=1 dout=12345678", rvalid[0], dout[0]);
    end
  endtask

  task automatic test_read_latency2;
    logic        exp_v;
    logic [31:0] exp_d;
    for (int i = 1; i <= 4; i++) wr(1, 9'(i), 32'h000000A0 + 32'(i), 4'hF);
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 9'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = (k >= 2) && (k <= 5);
      exp_d = 32'h000000A0 + 32'(k - 1);
      total++;
      if (rvalid[1] !== exp_v || (exp_v && dout[1] !== exp_d)) begin
        bad++;
        $display("FAIL lat2_stream k=%0d rvalid=%b dout=%h expected rvalid=%b dout=%h",
                 k, rvalid[1], dout[1], exp_v, exp_d);
      end
      if (k <= 3) addr[1] = 9'(k + 1);
      else        ce[1] = 1'b0;
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    int errs;
    @(negedge clk); rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    repeat (100) @(negedge clk);
    rst[0] = 1'b1;
    #1;
    total++;
    if (busy[0] !== 1'b1 || dout[0] !== 32'h0 || rvalid[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_state busy=%b dout=%h rvalid=%b expected 1/0/0", busy[0], dout[0], rvalid[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    ce[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'd5;
    n = 0;
    errs = 0;
    while (busy[0] === 1'b1 && n < 2000) begin
      if (rvalid[0] !== 1'b0 || dout[0] !== 32'h0) errs++;
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== 512) begin
      bad++;
      $display("FAIL restart_busy_len got=%0d cycles expected=512", n);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL read_during_busy got=%0d bad cycles expected=0", errs);
    end
    @(negedge clk);
    ce[0] = 1'b0;
    total++;
    if (rvalid[0] !== 1'b1 || dout[0] !== 32'h0) begin
      bad++;
      $display("FAIL cleared_word rvalid=%b dout=%h expected rvalid=1 dout=00000000", rvalid[0], dout[0]);
    end
  endtask

  task automatic test_no_clear;
    wr(2, 9'd7, 32'h5A5A5A5A, 4'hF);
    @(negedge clk); rst[2] = 1'b1;
    #1;
    total++;
    if (busy[2] !== 1'b0) begin
      bad++;
      $display("FAIL noclr_busy_in_reset got=%b expected=0", busy[2]);
    end
    @(negedge clk); rst[2] = 1'b0;
    rd(2, 9'd7);
    total++;
    if (busy[2] !== 1'b0 || rvalid[2] !== 1'b1 || dout[2] !== 32'h5A5A5A5A) begin
      bad++;
      $display("FAIL noclr_keep busy=%b rvalid=%b dout=%h expected busy=0 rvalid=1 dout=5a5a5a5a",
               busy[2], rvalid[2], dout[2]);
    end
  endtask

`ifdef SRAM22_PARITY_EN
  task automatic test_parity;
    perr_inj[0] = 1'b1;
    wr(0, 9'd3, 32'h00001700, 4'b0010);
    perr_inj[0] = 1'b0;
    rd(0, 9'd3);
    total++;
    if (rvalid[0] !== 1'b1 || perr[0] !== 1'b1) begin
      bad++;
      $display("FAIL parity_inject rvalid=%b perr=%b expected 1/1", rvalid[0], perr[0]);
    end
    @(negedge clk);
    total++;
    if (perr[0] !== 1'b0) begin
      bad++;
      $display("FAIL parity_pulse perr=%b expected=0", perr[0]);
    end
    wr(0, 9'd3, 32'h00001700, 4'b0010);
    rd(0, 9'd3);
    total++;
    if (rvalid[0] !== 1'b1 || perr[0] !== 1'b0) begin
      bad++;
      $display("FAIL parity_clean rvalid=%b perr=%b expected 1/0", rvalid[0], perr[0]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; ce[i] = 1'b0; we[i] = 1'b0; wmask[i] = 4'h0;
      addr[i] = 9'd0; din[i] = 32'h0;
`ifdef SRAM22_PARITY_EN
      perr_inj[i] = 1'b0;
`endif
    end
    test_reset;
    test_clear_read;
    test_wmask;
    test_back_to_back;
    test_read_latency2;
    test_reset_mid_sweep;
    test_no_clear;
`ifdef SRAM22_PARITY_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
